// File: rtl/mul_result_queue.sv
// Result capture behind the sequential multiplier: tracks the busy-phase product and cycle
// count, then commits each finished result into a small first-word-fall-through queue.
module mul_result_queue #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           in,
  input  logic                       done,
  output logic [WIDTH-1:0]           live_data,
  output logic [CNT_W-1:0]           live_cycles,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [CNT_W-1:0]           out_cycles,
  output logic                       out_sat,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       overflow
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = WIDTH + CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Returns {next_count, next_sat}; the count sticks at its maximum and flags saturation.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic sat);
    if (cnt == CNT_MAX) return {cnt, 1'b1};
    return {cnt + CNT_W'(1), sat};
  endfunction

  logic [WIDTH-1:0] live_data_q, live_data_d;
  logic [CNT_W-1:0] live_cycles_q, live_cycles_d;
  logic             sat_q, sat_d;
  logic             done_q_q, done_q_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [ENT_W-1:0] last_q, last_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] head;
  logic             is_full, is_valid, push, pop, wr_en;

  assign is_full  = (level_q == LVL_W'(DEPTH));
  assign is_valid = (level_q != '0);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    live_data_d   = live_data_q;
    live_cycles_d = live_cycles_q;
    sat_d         = sat_q;
    done_q_d      = done_q_q;
    overflow_d    = overflow_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    last_d        = last_q;
    push          = 1'b0;
    pop           = 1'b0;
    wr_en         = 1'b0;
    if (clear) begin
      live_data_d   = '0;
      live_cycles_d = '0;
      sat_d         = 1'b0;
      done_q_d      = 1'b1;
      overflow_d    = 1'b0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      level_d       = '0;
      last_d        = '0;
    end else begin
      done_q_d = done;
      push     = done && !done_q_q;
      pop      = is_valid && out_ready;
      if (!done) begin
        live_data_d                  = in;
        {live_cycles_d, sat_d}       = sat_inc(live_cycles_q, sat_q);
      end else if (push) begin
        live_cycles_d = '0;
        sat_d         = 1'b0;
      end
      // A full queue still accepts the commit when the head leaves on the same edge.
      wr_en = push && (!is_full || pop);
      if (push && is_full && !pop) overflow_d = 1'b1;
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        last_d   = head;
      end
      case ({wr_en, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_data_q   <= '0;
      live_cycles_q <= '0;
      sat_q         <= 1'b0;
      done_q_q      <= 1'b1;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      last_q        <= '0;
    end else begin
      live_data_q   <= live_data_d;
      live_cycles_q <= live_cycles_d;
      sat_q         <= sat_d;
      done_q_q      <= done_q_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      last_q        <= last_d;
    end
  end

  // Storage holds data only; occupancy decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {live_data_q, live_cycles_q, sat_q};
  end

  assign live_data   = live_data_q;
  assign live_cycles = live_cycles_q;
  assign out_valid   = is_valid;
  assign level       = level_q;
  assign full        = is_full;
  assign overflow    = overflow_q;
  assign {out_data, out_cycles, out_sat} = is_valid ? head : last_q;

endmodule

// File: tb/tb_mul_result_queue.sv
// Directed bench for mul_result_queue: capture, saturation, fill/overflow, full-with-pop,
// clear, asynchronous reset and long done pulses.
module tb_mul_result_queue;
  logic        clk = 1'b0;
  logic        rst, clear, done, out_ready;
  logic [15:0] in;
  logic [15:0] live_data, out_data;
  logic [2:0]  live_cycles, out_cycles, level;
  logic        out_valid, out_sat, full, overflow;
  int checks = 0;
  int failures = 0;

  mul_result_queue #(.WIDTH(16), .CNT_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in(in), .done(done),
    .live_data(live_data), .live_cycles(live_cycles), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_cycles(out_cycles),
    .out_sat(out_sat), .level(level), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One busy edge capturing val, then the commit edge.
  task automatic op(input logic [15:0] val);
    done = 1'b0; in = val; tick();
    done = 1'b1; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] exp_q [4];
    rst = 1'b1; clear = 1'b0; done = 1'b1; out_ready = 1'b0; in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_live_data", 32'(live_data), 0);
    chk("rst_live_cycles", 32'(live_cycles), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_cycles", 32'(out_cycles), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_overflow", 32'(overflow), 0);

    // Basic capture and commit
    done = 1'b0; in = 16'h0010; tick();
    chk("cap_latency", 32'(live_data), 32'h10);
    in = 16'h0020; tick();
    in = 16'h0031; tick();
    chk("basic_live_data", 32'(live_data), 32'h31);
    chk("basic_live_cycles", 32'(live_cycles), 3);
    chk("basic_no_commit", 32'(out_valid), 0);
    done = 1'b1; tick();
    chk("basic_out_valid", 32'(out_valid), 1);
    chk("basic_out_data", 32'(out_data), 32'h31);
    chk("basic_out_cycles", 32'(out_cycles), 3);
    chk("basic_out_sat", 32'(out_sat), 0);
    chk("basic_live_cycles_clr", 32'(live_cycles), 0);
    chk("basic_live_hold", 32'(live_data), 32'h31);
    tick();
    chk("basic_hold_level", 32'(level), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("pop_empty_valid", 32'(out_valid), 0);
    chk("pop_last_data", 32'(out_data), 32'h31);
    chk("pop_level", 32'(level), 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("pop_when_empty_level", 32'(level), 0);

    // Saturation followed by a long done pulse
    done = 1'b0; in = 16'h0055;
    for (int i = 0; i < 10; i++) tick();
    chk("sat_live_cycles", 32'(live_cycles), 7);
    done = 1'b1; tick();
    chk("sat_out_cycles", 32'(out_cycles), 7);
    chk("sat_out_sat", 32'(out_sat), 1);
    chk("sat_out_data", 32'(out_data), 32'h55);
    for (int i = 0; i < 5; i++) tick();
    chk("long_pulse_level", 32'(level), 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Fill and overflow
    for (int v = 1; v <= 4; v++) op(16'(v));
    chk("fill_level", 32'(level), 4);
    chk("fill_full", 32'(full), 1);
    chk("fill_no_ovf", 32'(overflow), 0);
    op(16'd5);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_level", 32'(level), 4);
    chk("ovf_head", 32'(out_data), 1);
    out_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      chk("drain_data", 32'(out_data), 32'(v));
      chk("drain_cycles", 32'(out_cycles), 1);
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", 32'(out_valid), 0);
    chk("ovf_sticky", 32'(overflow), 1);

    // Clear mid-operation
    op(16'h000A); op(16'h000B);
    done = 1'b0; in = 16'h0077; tick();
    chk("pre_clear_level", 32'(level), 2);
    clear = 1'b1; out_ready = 1'b1; tick();
    clear = 1'b0; out_ready = 1'b0; done = 1'b1;
    chk("clear_level", 32'(level), 0);
    chk("clear_valid", 32'(out_valid), 0);
    chk("clear_overflow", 32'(overflow), 0);
    chk("clear_live_cycles", 32'(live_cycles), 0);
    chk("clear_live_data", 32'(live_data), 0);
    chk("clear_out_data", 32'(out_data), 0);
    tick();
    chk("clear_no_commit", 32'(level), 0);

    // Full queue with a simultaneous pop
    for (int v = 0; v < 4; v++) op(16'(16'h21 + v));
    chk("full2_full", 32'(full), 1);
    done = 1'b0; in = 16'h0025; tick();
    done = 1'b1; out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("fullpop_overflow", 32'(overflow), 0);
    chk("fullpop_level", 32'(level), 4);
    exp_q = '{16'h22, 16'h23, 16'h24, 16'h25};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fullpop_order", 32'(out_data), 32'(exp_q[i]));
      tick();
    end
    out_ready = 1'b0;
    chk("fullpop_empty", 32'(out_valid), 0);

    // Asynchronous reset between edges
    op(16'h0099);
    done = 1'b0; in = 16'h0005; tick();
    chk("pre_rst_level", 32'(level), 1);
    chk("pre_rst_cycles", 32'(live_cycles), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_live_cycles", 32'(live_cycles), 0);
    chk("arst_live_data", 32'(live_data), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_overflow", 32'(overflow), 0);
    done = 1'b1;
    #1 rst = 1'b0;
    tick();
    chk("post_rst_no_commit", 32'(level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_result_queue.md
# mul_result_queue

Parametrised result-capture stage that sits behind the sequential multiplier. While the multiplier's `done` is low, it tracks the multiplier output and counts busy cycles. When `done` rises, it commits the final product and its cycle count into a small first-word-fall-through queue. A downstream consumer drains the queue with a valid/ready handshake, so results are no longer overwritten by the next multiply.

## Interface
Parameters:
- `WIDTH`, 16: product width in bits.
- `CNT_W`, 3: busy-cycle counter width.
- `DEPTH`, 4: queue entries; power of two, ≥2.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous clear; highest priority after `rst`.
- `in` in WIDTH: multiplier product bus.
- `done` in 1: multiplier status; 0 = busy, 1 = finished/idle.
- `live_data` out WIDTH: last value of `in` captured while busy.
- `live_cycles` out CNT_W: busy cycles counted for the current operation.
- `out_valid` out 1: queue non-empty.
- `out_ready` in 1: consumer accepts the head entry.
- `out_data` out WIDTH: head entry product.
- `out_cycles` out CNT_W: head entry cycle count.
- `out_sat` out 1: head entry's cycle count saturated.
- `level` out $clog2(DEPTH+1): queue occupancy.
- `full` out 1: `level == DEPTH`.
- `overflow` out 1: sticky; a commit was dropped.

## Operation
- **Reset values:** `live_data`=0, `live_cycles`=0, `out_valid`=0, `out_data`=0, `out_cycles`=0, `out_sat`=0, `level`=0, `full`=0, `overflow`=0. The internal `done_q` resets to 1, so no commit is generated out of reset.
- **Capture:** each edge with `done`=0:
  - `live_data` <= `in`.
  - `live_cycles` <= `live_cycles`+1, saturating at 2^CNT_W−1. No wrap.
  - The internal `sat` flag is set when an increment would exceed the maximum.
- **Hold:** with `done`=1 and no commit, `live_data` and `live_cycles` hold.
- **Commit:** the edge where `done`=1 and `done_q`=0.
  - Push {`live_data`, `live_cycles`, `sat`} as held before the edge.
  - The same edge sets `live_cycles` <= 0 and `sat` <= 0.
  - `live_data` holds.
- **Pop:** `out_valid` && `out_ready` at an edge removes the head entry.
- **Push when full:**
  - Without a simultaneous pop, the entry is dropped, `overflow` <= 1, and queue contents are unchanged.
  - With a simultaneous pop, both occur and `level` stays at DEPTH.
- **Empty:** a pop request while empty is ignored.
- **Simultaneous push and pop, non-full, non-empty:** `level` unchanged; order preserved.
- **`clear`=1:**
  - Empties the queue and sets `level`=0.
  - Zeroes `live_data`, `live_cycles`, `sat` and `overflow`.
  - Sets `done_q` <= 1.
  - Ignores `done` and `out_ready` that cycle.
- **`rst` mid-operation:** immediate return to reset values. A partially counted operation is discarded.
- **Head outputs:** `out_data`, `out_cycles` and `out_sat` are driven from the head entry (FWFT). When empty they hold the last popped values; 0 after reset or clear.

## Timing
- Capture latency 1: `in` sampled at edge k appears on `live_data` after edge k.
- Commit-to-output latency 1: with `done` rising before edge k and the queue empty, `out_valid`=1 after edge k. There is no combinational bypass from `in`/`done` to the `out_*` ports.
- `out_valid`, `level` and `full` are registered or derived only from registered pointers. `out_ready` does not combinationally affect any output.
- Throughput: one push and one pop per cycle.
- Minimum spacing between commits is 2 cycles: `done` must be low for at least one edge.
- A `done` pulse longer than one cycle produces exactly one commit.
- Pointers wrap modulo DEPTH; `level` disambiguates full from empty.

## Test plan
- **Basic:** reset; hold `done`=0 for 3 edges with `in`=0x0010, 0x0020, 0x0031; then raise `done` → after the commit edge `out_valid`=1, `out_data`=0x0031, `out_cycles`=3, `out_sat`=0, `live_cycles`=0.
- **Saturation:** `done`=0 for 10 edges with CNT_W=3 → `live_cycles` stops at 7; the committed entry has `out_cycles`=7 and `out_sat`=1.
- **Fill/overflow:** `out_ready`=0; perform 5 operations with products 1..5 → `full`=1, `level`=4, `overflow`=1. Then drain with `out_ready`=1 → `out_data` reads 1, 2, 3, 4 on consecutive cycles, then `out_valid`=0.
- **Full with simultaneous pop:** queue full; commit with `out_ready`=1 on the same edge → `overflow` stays 0, `level` stays 4, the new entry lands last.
- **Clear/reset mid-operation:**
  - Assert `clear` with 2 entries queued, `overflow`=1 and `done`=0 → next cycle `level`=0, `out_valid`=0, `overflow`=0, `live_cycles`=0.
  - Async `rst` between edges → outputs go to reset values immediately.
- **Long `done` pulse:** `done` high for 6 cycles after a busy phase → exactly one entry pushed; `level` increases by 1 only.
